// File: rtl/wakeup_frame_sync_pkg.sv
// Shared types and elaboration helpers for the wake-up / frame synchroniser.
package wakeup_sync_pkg;

  // Frame controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Width of a counter that must reach NBITS inclusive.
  function automatic int bit_cnt_width(input int nbits);
    return $clog2(nbits + 1);
  endfunction

  // True when the parameter set can produce a well-formed frame.
  function automatic bit params_legal(
    input int div,
    input int delay,
    input int timeout,
    input int nbits,
    input int preamble_bits,
    input int tim_w
  );
    return (div >= 2) && ((div % 2) == 0) &&
           (delay < timeout) &&
           (nbits >= 1) &&
           (preamble_bits <= nbits) &&
           ((tim_w >= 32) || ((longint'(1) << tim_w) > longint'(timeout)));
  endfunction

endpackage

// File: rtl/async_rise_det.sv
// Three-flop synchroniser for one asynchronous input with a one-cycle
// rising-edge pulse taken from the two oldest (settled) stages.
module async_rise_det (
  input  logic clki,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sh_r;

  // Shift the asynchronous level through the synchroniser chain.
  always_ff @(posedge clki) begin
    if (!rst_n) begin
      sh_r <= 3'b000;
    end else begin
      sh_r <= {sh_r[1:0], async_in};
    end
  end

  assign rise = (sh_r[2:1] == 2'b01);

endmodule

// File: rtl/wakeup_frame_sync.sv
// Wake-up / frame synchroniser: arms on a wake_up rise, starts a data phase
// after a programmable delay, produces a divided data clock, bit counter and
// the T0/T1 test pattern, and reports done / timeout.
// Build option: COMP_EDGE_ALIGN_EN aligns the data-phase start to the first
// comp_out rise at or after DELAY and enables the timeout abort.
module wakeup_frame_sync
  import wakeup_sync_pkg::*;
#(
  parameter int DIV           = 100,
  parameter int DELAY         = 25342,
  parameter int TIMEOUT       = 60000,
  parameter int NBITS         = 1000,
  parameter int PREAMBLE_BITS = 432,
  parameter int TIM_W         = 20
) (
  input  logic                              clki,
  input  logic                              rst_n,
  input  logic                              wake_up,
  input  logic                              comp_out,
  output logic                              wu_valid,
  output logic                              data_clk_enb,
  output logic                              data_clk,
  output logic                              t0,
  output logic                              t1,
  output logic [bit_cnt_width(NBITS)-1:0]   bit_cnt,
  output logic                              done,
  output logic                              timeout
);

  localparam int BC_W  = bit_cnt_width(NBITS);
  localparam int DIV_W = $clog2(DIV);

  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(DIV / 2 - 1);
  localparam logic [TIM_W-1:0] DELAY_C = TIM_W'(DELAY);
  localparam logic [BC_W-1:0]  NBITS_C = BC_W'(NBITS);
  localparam logic [BC_W-1:0]  PRE_C   = BC_W'(PREAMBLE_BITS);

  if (!params_legal(DIV, DELAY, TIMEOUT, NBITS, PREAMBLE_BITS, TIM_W)) begin : g_param_error
    $error("wakeup_frame_sync: illegal parameter set");
  end

  state_t            state_r, state_nxt_s;
  logic [TIM_W-1:0]  tim_cnt_r, tim_cnt_nxt_s;
  logic [DIV_W-1:0]  div_cnt_r, div_cnt_nxt_s;
  logic [BC_W-1:0]   bit_cnt_r, bit_cnt_nxt_s;
  logic              wu_valid_r, wu_valid_nxt_s;
  logic              enb_r, enb_nxt_s;
  logic              data_clk_r, data_clk_nxt_s;
  logic              t0_r, t0_nxt_s;
  logic              t1_r, t1_nxt_s;
  logic              done_r, done_nxt_s;
  logic              timeout_r, timeout_nxt_s;

  logic              wake_rise_s;
  logic              start_s;
  logic              expire_s;
  logic              toggle_s;
  logic              frame_end_s;

  async_rise_det u_wake_det (
    .clki     (clki),
    .rst_n    (rst_n),
    .async_in (wake_up),
    .rise     (wake_rise_s)
  );

`ifdef COMP_EDGE_ALIGN_EN
  localparam logic [TIM_W-1:0] TIMEOUT_C = TIM_W'(TIMEOUT);

  logic comp_rise_s;

  async_rise_det u_comp_det (
    .clki     (clki),
    .rst_n    (rst_n),
    .async_in (comp_out),
    .rise     (comp_rise_s)
  );

  assign start_s  = comp_rise_s && (tim_cnt_r >= DELAY_C);
  assign expire_s = (tim_cnt_r == TIMEOUT_C);
`else
  // comp_out has no role when the start is purely delay based.
  logic comp_unused_s;
  assign comp_unused_s = comp_out;

  assign start_s  = (tim_cnt_r == DELAY_C);
  assign expire_s = 1'b0;
`endif

  assign toggle_s    = (div_cnt_r == HALF_M1);
  assign frame_end_s = (bit_cnt_r == NBITS_C);

  // State and datapath registers, cleared by the synchronous reset.
  always_ff @(posedge clki) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      tim_cnt_r  <= '0;
      div_cnt_r  <= '0;
      bit_cnt_r  <= '0;
      wu_valid_r <= 1'b0;
      enb_r      <= 1'b0;
      data_clk_r <= 1'b0;
      t0_r       <= 1'b0;
      t1_r       <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tim_cnt_r  <= tim_cnt_nxt_s;
      div_cnt_r  <= div_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      wu_valid_r <= wu_valid_nxt_s;
      enb_r      <= enb_nxt_s;
      data_clk_r <= data_clk_nxt_s;
      t0_r       <= t0_nxt_s;
      t1_r       <= t1_nxt_s;
      done_r     <= done_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  // Next-state selection; a start beats an expiry in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (wake_rise_s) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED: begin
        if (start_s) begin
          state_nxt_s = RUN;
        end else if (expire_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      RUN: begin
        if (frame_end_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Next values of counters and registered outputs for the current state.
  always_comb begin
    tim_cnt_nxt_s  = tim_cnt_r;
    div_cnt_nxt_s  = div_cnt_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    wu_valid_nxt_s = wu_valid_r;
    enb_nxt_s      = enb_r;
    data_clk_nxt_s = data_clk_r;
    t0_nxt_s       = t0_r;
    t1_nxt_s       = t1_r;
    done_nxt_s     = 1'b0;
    timeout_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (wake_rise_s) begin
          tim_cnt_nxt_s  = '0;
          wu_valid_nxt_s = 1'b1;
        end else begin
          wu_valid_nxt_s = 1'b0;
        end
      end
      ARMED: begin
        tim_cnt_nxt_s = tim_cnt_r + TIM_W'(1);
        if (start_s) begin
          wu_valid_nxt_s = 1'b0;
          enb_nxt_s      = 1'b1;
          data_clk_nxt_s = 1'b0;
          div_cnt_nxt_s  = HALF_M1;
          bit_cnt_nxt_s  = '0;
          t0_nxt_s       = 1'b0;
          t1_nxt_s       = 1'b0;
        end else if (expire_s) begin
          wu_valid_nxt_s = 1'b0;
          timeout_nxt_s  = 1'b1;
        end else begin
          wu_valid_nxt_s = 1'b1;
        end
      end
      RUN: begin
        if (frame_end_s) begin
          // Last falling edge already counted: close the frame.
          enb_nxt_s      = 1'b0;
          data_clk_nxt_s = 1'b0;
          t0_nxt_s       = 1'b0;
          t1_nxt_s       = 1'b0;
          div_cnt_nxt_s  = '0;
          done_nxt_s     = 1'b1;
        end else if (toggle_s) begin
          div_cnt_nxt_s  = '0;
          data_clk_nxt_s = ~data_clk_r;
          if (!data_clk_r) begin
            // Rising data_clk: present the pattern bit for bit_cnt.
            t0_nxt_s = (bit_cnt_r < PRE_C);
            if (bit_cnt_r < PRE_C) begin
              t1_nxt_s = 1'b0;
            end else begin
              t1_nxt_s = ~t1_r;
            end
          end else begin
            // Falling data_clk completes the current bit.
            bit_cnt_nxt_s = bit_cnt_r + BC_W'(1);
          end
        end else begin
          div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        tim_cnt_nxt_s  = '0;
        div_cnt_nxt_s  = '0;
        bit_cnt_nxt_s  = '0;
        wu_valid_nxt_s = 1'b0;
        enb_nxt_s      = 1'b0;
        data_clk_nxt_s = 1'b0;
        t0_nxt_s       = 1'b0;
        t1_nxt_s       = 1'b0;
      end
    endcase
  end

  assign wu_valid     = wu_valid_r;
  assign data_clk_enb = enb_r;
  assign data_clk     = data_clk_r;
  assign t0           = t0_r;
  assign t1           = t1_r;
  assign bit_cnt      = bit_cnt_r;
  assign done         = done_r;
  assign timeout      = timeout_r;

endmodule

// File: tb/tb_wakeup_frame_sync.sv
// Scoreboard bench for wakeup_frame_sync: every stimulus sequence pushes the
// expected per-cycle output vector; a negedge monitor pops and compares.
module tb_wakeup_frame_sync;

  localparam int DIV           = 4;
  localparam int DELAY         = 10;
  localparam int TIMEOUT       = 30;
  localparam int NBITS         = 8;
  localparam int PREAMBLE_BITS = 3;
  localparam int TIM_W         = 20;
  localparam int FRAME_CYC     = NBITS * DIV;

  logic       clki;
  logic       rst_n;
  logic       wake_up;
  logic       comp_out;
  logic       wu_valid;
  logic       data_clk_enb;
  logic       data_clk;
  logic       t0;
  logic       t1;
  logic [3:0] bit_cnt;
  logic       done;
  logic       timeout;

  int n_vec = 0;
  int n_bad = 0;

  logic [10:0] sb_q[$];

  wakeup_frame_sync #(
    .DIV           (DIV),
    .DELAY         (DELAY),
    .TIMEOUT       (TIMEOUT),
    .NBITS         (NBITS),
    .PREAMBLE_BITS (PREAMBLE_BITS),
    .TIM_W         (TIM_W)
  ) dut (
    .clki         (clki),
    .rst_n        (rst_n),
    .wake_up      (wake_up),
    .comp_out     (comp_out),
    .wu_valid     (wu_valid),
    .data_clk_enb (data_clk_enb),
    .data_clk     (data_clk),
    .t0           (t0),
    .t1           (t1),
    .bit_cnt      (bit_cnt),
    .done         (done),
    .timeout      (timeout)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected {wu_valid,data_clk_enb,data_clk,t0,t1,done,timeout,bit_cnt}
  // n clki edges after wake_up is first sampled high, with RUN entered on
  // edge r_edge.
  function automatic logic [10:0] frame_exp(input int n, input int r_edge, input int bc_prev);
    int   r;
    int   j;
    int   k;
    logic wu;
    logic en;
    logic dc;
    logic e0;
    logic e1;
    logic dn;
    logic [3:0] bc;
    wu = 1'b0; en = 1'b0; dc = 1'b0; e0 = 1'b0; e1 = 1'b0; dn = 1'b0;
    bc = 4'(bc_prev);
    if (n >= 3 && n < r_edge) wu = 1'b1;
    r = n - r_edge;
    if (r >= 0 && r < FRAME_CYC) begin
      en = 1'b1;
      bc = 4'd0;
      if (r > 0) begin
        j  = (r - 1) / (DIV / 2);
        dc = ((j % 2) == 0);
        bc = 4'((j + 1) / 2);
        k  = j / 2;
        e0 = (k < PREAMBLE_BITS);
        e1 = (k < PREAMBLE_BITS) ? 1'b0 : (((k - PREAMBLE_BITS) % 2) == 0);
      end
    end else if (r == FRAME_CYC) begin
      dn = 1'b1;
      bc = 4'(NBITS);
    end else if (r > FRAME_CYC) begin
      bc = 4'(NBITS);
    end
    return {wu, en, dc, e0, e1, dn, 1'b0, bc};
  endfunction

  // Expected vector for a window that expires without starting.
  function automatic logic [10:0] timeout_exp(input int n, input int bc_prev);
    logic wu;
    logic to;
    wu = (n >= 3) && (n <= 3 + TIMEOUT);
    to = (n == 4 + TIMEOUT);
    return {wu, 5'b00000, to, 4'(bc_prev)};
  endfunction

  // Compare each cycle's outputs against the next scoreboard entry.
  always @(negedge clki) begin
    if (sb_q.size() > 0) begin
      chk("outvec", {21'd0, wu_valid, data_clk_enb, data_clk, t0, t1, done, timeout, bit_cnt},
          {21'd0, sb_q.pop_front()});
    end
  end

  task automatic drain(input int budget);
    int left;
    left = budget;
    while (sb_q.size() > 0 && left > 0) begin
      @(posedge clki);
      left--;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  // Wake-up frame; extra adds wake pulses in ARMED/RUN, rst_at>0 resets then.
  task automatic run_frame(input bit extra, input int bc_prev, input int rst_at);
    int r_edge;
    int total;
    r_edge = 3 + DELAY + 1;
    total  = (rst_at > 0) ? rst_at + 6 : r_edge + FRAME_CYC + 3;
    @(posedge clki); #1;
    for (int n = 0; n <= total; n++) begin
      if (rst_at > 0 && n >= rst_at) sb_q.push_back(11'd0);
      else sb_q.push_back(frame_exp(n, r_edge, bc_prev));
    end
    wake_up = 1'b1;
    for (int k = 1; k <= total; k++) begin
      @(posedge clki); #1;
      if (k == 3) wake_up = 1'b0;
      if (extra) begin
        if (k == 6 || k == 20) wake_up = 1'b1;
        if (k == 8 || k == 23) wake_up = 1'b0;
        comp_out = ~comp_out;
      end
      if (rst_at > 0 && k == rst_at - 1) rst_n = 1'b0;
      if (rst_at > 0 && k == rst_at) rst_n = 1'b1;
    end
    comp_out = 1'b0;
    drain(20);
  endtask

  // Comparator-aligned window: comp_out sampled high at edge c.
  task automatic run_comp(input int c, input int bc_prev, input bit expect_to);
    int total;
    total = expect_to ? TIMEOUT + 8 : c + 2 + FRAME_CYC + 3;
    @(posedge clki); #1;
    for (int n = 0; n <= total; n++) begin
      if (expect_to) sb_q.push_back(timeout_exp(n, bc_prev));
      else sb_q.push_back(frame_exp(n, c + 2, bc_prev));
    end
    wake_up = 1'b1;
    for (int k = 1; k <= total; k++) begin
      @(posedge clki); #1;
      if (k == 3) wake_up = 1'b0;
      if (k == c - 1) comp_out = 1'b1;
      if (k == c + 2) comp_out = 1'b0;
    end
    drain(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    wake_up  = 1'b0;
    comp_out = 1'b0;
    // Reset held with both async inputs toggling: all outputs stay 0.
    for (int n = 0; n < 8; n++) sb_q.push_back(11'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clki); #1;
      wake_up  = ~wake_up;
      comp_out = (k % 3) == 0;
    end
    wake_up  = 1'b0;
    comp_out = 1'b0;
    drain(10);
    rst_n = 1'b1;
    repeat (4) @(posedge clki);
`ifdef COMP_EDGE_ALIGN_EN
    run_comp(7, 0, 1'b1);
    repeat (4) @(posedge clki);
    run_comp(19, 0, 1'b0);
`else
    run_frame(1'b0, 0, 0);
    repeat (4) @(posedge clki);
    run_frame(1'b1, NBITS, 0);
    repeat (4) @(posedge clki);
    run_frame(1'b0, NBITS, 3 + DELAY + 1 + 16);
    repeat (4) @(posedge clki);
    run_frame(1'b0, 0, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
